// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the iterative divider: FSM encodings, div_op bit positions, default width.
package div_sequencer_pkg;

    localparam int DATA_W_DEF    = 32;
    localparam int DIV_OP_SIGNED = 0;
    localparam int DIV_OP_MOD    = 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_CALC = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quot} left, subtract divisor if it fits.
// Purely combinational; the sequencer applies it once per CALC cycle.
module div_step
    import div_sequencer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W:0]   rem_i,
    input  logic [DATA_W-1:0] quot_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic [DATA_W:0]   rem_o,
    output logic [DATA_W-1:0] quot_o
);

    logic [DATA_W+1:0] shifted;
    logic [DATA_W:0]   trial;
    logic              take;

    // The partial remainder always stays below the divisor, so the extra top bit only guards the compare.
    assign shifted = {rem_i, quot_i[DATA_W-1]};
    assign take    = shifted >= {2'b00, divisor_i};
    assign trial   = shifted[DATA_W:0] - {1'b0, divisor_i};
    assign rem_o   = take ? trial : shifted[DATA_W:0];
    assign quot_o  = {quot_i[DATA_W-2:0], take};

endmodule

// File: rtl/div_sequencer.sv
// Iterative div.w/div.wu/mod.w/mod.wu unit: DATA_W+3 cycles accept-to-result, 3 cycles on divide-by-zero.
// One op in flight; in_ready only in IDLE, result held while out_valid & ~out_ready; cancel aborts at any point.
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        div_op,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    input  logic              cancel,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W:0]   rem_q, rem_d;
    logic [DATA_W-1:0] quot_q, quot_d;
    logic              q_neg_q, q_neg_d;
    logic              r_neg_q, r_neg_d;
    logic              dz_q, dz_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              out_valid_q, out_valid_d;

    logic [DATA_W:0]   step_rem;
    logic [DATA_W-1:0] step_quot;
    logic [DATA_W-1:0] a_mag, b_mag, q_fix, r_fix;

    div_step #(.DATA_W(DATA_W)) u_step (
        .rem_i     (rem_q),
        .quot_i    (quot_q),
        .divisor_i (b_q),
        .rem_o     (step_rem),
        .quot_o    (step_quot)
    );

    assign a_mag = (op_q[DIV_OP_SIGNED] && a_q[DATA_W-1]) ? -a_q : a_q;
    assign b_mag = (op_q[DIV_OP_SIGNED] && b_q[DATA_W-1]) ? -b_q : b_q;
    // Divide-by-zero keeps the all-ones quotient and raw dividend untouched.
    assign q_fix = (q_neg_q && !dz_q) ? -quot_q : quot_q;
    assign r_fix = (r_neg_q && !dz_q) ? -rem_q[DATA_W-1:0] : rem_q[DATA_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rem_q       <= '0;
            quot_q      <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            dz_q        <= 1'b0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rem_q       <= rem_d;
            quot_q      <= quot_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            dz_q        <= dz_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        rem_d       = rem_q;
        quot_d      = quot_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        dz_d        = dz_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && !cancel) begin
                    op_d    = div_op;
                    a_d     = src1;
                    b_d     = src2;
                    q_neg_d = div_op[DIV_OP_SIGNED] && (src1[DATA_W-1] ^ src2[DATA_W-1]);
                    r_neg_d = div_op[DIV_OP_SIGNED] && src1[DATA_W-1];
                    state_d = ST_PREP;
                end
            end
            ST_PREP: begin
                cnt_d = '0;
                dz_d  = (b_q == '0);
                if (b_q == '0) begin
                    quot_d  = '1;
                    rem_d   = {1'b0, a_q};
                    state_d = ST_FIX;
                end else begin
                    quot_d  = a_mag;
                    rem_d   = '0;
                    b_d     = b_mag;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                rem_d  = step_rem;
                quot_d = step_quot;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                result_d    = op_q[DIV_OP_MOD] ? r_fix : q_fix;
                out_valid_d = 1'b1;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (cancel) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed and random checks of div_sequencer against an arithmetic reference model.
module tb_div_sequencer;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    div_op;
    logic [DW-1:0] src1, src2;
    logic          cancel;
    logic          busy;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] result;

    int vectors     = 0;
    int miscompares = 0;

    div_sequencer #(.DATA_W(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .div_op    (div_op),
        .src1      (src1),
        .src2      (src2),
        .cancel    (cancel),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] ref_div(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] q, r;
        int sa, sb;
        sa = a;
        sb = b;
        if (b == 0) begin
            q = '1;
            r = a;
        end else if (op[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = '0;
            end else begin
                q = sa / sb;
                r = sa % sb;
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        return op[1] ? r : q;
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one op, checks latency/busy/result, then consumes it after holding out_ready low for 'hold' cycles.
    task automatic run_op(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] exp, input int hold, input string tag);
        int lat;
        int waited;
        @(negedge clk);
        waited = 0;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        div_op    = op;
        src1      = a;
        src2      = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        src1     = $urandom;
        src2     = $urandom;
        div_op   = 2'($urandom);
        lat      = 1;
        @(negedge clk);
        check({tag, " busy"}, {31'b0, busy}, 32'd1);
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, " latency"}, lat, (b == 0) ? 32'd3 : 32'(DW + 3));
        check({tag, " result"}, result, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " held valid"}, {31'b0, out_valid}, 32'd1);
            check({tag, " held result"}, result, exp);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check({tag, " in_ready after"}, {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [1:0]    rop;
        logic [DW-1:0] ra, rb;
        int            sel;
        bit            seen;
        int            waited;

        reset     = 1'b1;
        in_valid  = 1'b0;
        div_op    = 2'b00;
        src1      = '0;
        src2      = '0;
        cancel    = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset in_ready", {31'b0, in_ready}, 32'd1);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset out_valid", {31'b0, out_valid}, 32'd0);
        check("reset result", result, 32'd0);

        run_op(2'b00, 32'd100, 32'd7, 32'd14, 0, "udiv 100/7");
        run_op(2'b10, 32'd100, 32'd7, 32'd2, 0, "umod 100/7");
        run_op(2'b01, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, "sdiv -7/2");
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0, "smod -7/2");
        run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, "sdiv min/-1");
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, "smod min/-1");
        run_op(2'b00, 32'h1234, 32'd0, 32'hFFFF_FFFF, 0, "udiv by 0");
        run_op(2'b10, 32'h1234, 32'd0, 32'h1234, 0, "umod by 0");
        run_op(2'b11, 32'h8000_1234, 32'd0, 32'h8000_1234, 0, "smod by 0");
        run_op(2'b00, 32'd1000, 32'd9, 32'd111, 5, "stall 5");

        // cancel during the 10th CALC cycle
        @(negedge clk);
        in_valid = 1'b1;
        div_op   = 2'b00;
        src1     = 32'd1000;
        src2     = 32'd3;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 cancel = 1'b1;
        @(posedge clk);
        #1 cancel = 1'b0;
        @(negedge clk);
        check("cancel in_ready", {31'b0, in_ready}, 32'd1);
        check("cancel busy", {31'b0, busy}, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("cancel no out_valid", {31'b0, seen}, 32'd0);
        run_op(2'b01, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 0, "after cancel");

        // cancel together with in_valid must not accept
        @(negedge clk);
        in_valid = 1'b1;
        cancel   = 1'b1;
        src1     = 32'd5;
        src2     = 32'd1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cancel   = 1'b0;
        @(negedge clk);
        check("cancel+valid busy", {31'b0, busy}, 32'd0);

        // cancel in DONE with out_ready=1 wins
        out_ready = 1'b0;
        in_valid  = 1'b1;
        div_op    = 2'b00;
        src1      = 32'd50;
        src2      = 32'd5;
        @(posedge clk);
        #1 in_valid = 1'b0;
        waited = 0;
        @(negedge clk);
        while (!out_valid && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("done result", result, 32'd10);
        cancel    = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 cancel = 1'b0;
        @(negedge clk);
        check("done cancel out_valid", {31'b0, out_valid}, 32'd0);
        check("done cancel in_ready", {31'b0, in_ready}, 32'd1);

        // reset mid-operation clears result
        in_valid = 1'b1;
        src1     = 32'd77;
        src2     = 32'd3;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midreset result", result, 32'd0);
        check("midreset in_ready", {31'b0, in_ready}, 32'd1);
        check("midreset out_valid", {31'b0, out_valid}, 32'd0);

        for (int n = 0; n < 40; n++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0: rb = '0;
                1: begin rb = 32'hFFFF_FFFF; if (n % 2 == 0) ra = 32'h8000_0000; end
                2: rb = $urandom_range(1, 15);
                3: rb = 32'hFFFF_FFFF - $urandom_range(0, 15);
                default: rb = $urandom;
            endcase
            run_op(rop, ra, rb, ref_div(rop, ra, rb), $urandom_range(0, 2), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
